// File: rtl/sensor_event_gen.sv
// Sensor front-end: thresholds, hysteresis and persistence filtering
// of raw samples into enable/warning/alarm/vent events, plus a watchdog.
module sensor_event_gen #(
    parameter int WIDTH      = 8,
    parameter int WARN_TH    = 100,
    parameter int ALARM_TH   = 150,
    parameter int HYST       = 10,
    parameter int PERSIST    = 3,
    parameter int VENT_DELAY = 5,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             en_o,
    output logic             aviso,
    output logic             alarma,
    output logic             vent,
    output logic             sensor_fault,
    output logic [2:0]       level
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NORMAL = 3'd1,
        WARN   = 3'd2,
        ALARM  = 3'd3,
        VENT   = 3'd4
    } state_t;

    localparam int PW = $clog2(PERSIST + 1);
    localparam int VW = $clog2(VENT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Falling thresholds saturate at zero, making the down condition unreachable.
    localparam int W_LO_I = (WARN_TH > HYST) ? WARN_TH - HYST : 0;
    localparam int A_LO_I = (ALARM_TH > HYST) ? ALARM_TH - HYST : 0;

    localparam logic [WIDTH:0] W_HI  = (WIDTH+1)'(WARN_TH);
    localparam logic [WIDTH:0] A_HI  = (WIDTH+1)'(ALARM_TH);
    localparam logic [WIDTH:0] W_LO  = (WIDTH+1)'(W_LO_I);
    localparam logic [WIDTH:0] A_LO  = (WIDTH+1)'(A_LO_I);
    localparam logic [PW:0]    P_LIM = (PW+1)'(PERSIST);
    localparam logic [VW-1:0]  V_LIM = VW'(VENT_DELAY);
    localparam logic [TW-1:0]  T_LST = TW'(TIMEOUT - 1);

    state_t         state, state_n;
    logic [PW-1:0]  pcnt, pcnt_n, pbase;
    logic [PW:0]    pnext;
    logic           pdir, pdir_n;
    logic [VW-1:0]  vcnt, vcnt_n, vnext;
    logic [TW-1:0]  wd, wd_n;
    logic           fault_n;
    logic [WIDTH:0] s;
    logic           up, dn;
    state_t         up_tgt, dn_tgt;

    assign s = {1'b0, sample};

    always_comb begin
        up     = 1'b0;
        dn     = 1'b0;
        up_tgt = state;
        dn_tgt = state;
        unique case (state)
            NORMAL: begin
                up     = s >= W_HI;
                up_tgt = WARN;
            end
            WARN: begin
                up     = s >= A_HI;
                dn     = s < W_LO;
                up_tgt = ALARM;
                dn_tgt = NORMAL;
            end
            ALARM: begin
                dn     = s < A_LO;
                dn_tgt = WARN;
            end
            VENT: begin
                dn     = s < A_LO;
                dn_tgt = NORMAL;
            end
            default: ;
        endcase
    end

    // A run in the opposite direction restarts the shared count from zero.
    assign pbase = (pdir == up) ? pcnt : '0;
    assign pnext = (PW+1)'(pbase) + (PW+1)'(1);
    assign vnext = vcnt + VW'(1);

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        pdir_n  = pdir;
        vcnt_n  = vcnt;
        wd_n    = wd;
        fault_n = sensor_fault;
        if (!enable) begin
            state_n = IDLE;
            pcnt_n  = '0;
            pdir_n  = 1'b0;
            vcnt_n  = '0;
            wd_n    = '0;
            fault_n = 1'b0;
        end else if (state == IDLE) begin
            state_n = NORMAL;
        end else if (sensor_fault) begin
            state_n = state;
        end else if (!sample_valid) begin
            wd_n = wd + TW'(1);
            if (wd == T_LST) fault_n = 1'b1;
        end else begin
            wd_n = '0;
            if (up || dn) begin
                pcnt_n = pnext[PW-1:0];
                pdir_n = up;
            end else begin
                pcnt_n = '0;
            end
            if (state == ALARM) vcnt_n = vnext;
            if ((up || dn) && pnext >= P_LIM) begin
                state_n = up ? up_tgt : dn_tgt;
                pcnt_n  = '0;
                pdir_n  = 1'b0;
                vcnt_n  = '0;
            end else if (state == ALARM && vnext >= V_LIM) begin
                state_n = VENT;
                pcnt_n  = '0;
                pdir_n  = 1'b0;
                vcnt_n  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pcnt         <= '0;
            pdir         <= 1'b0;
            vcnt         <= '0;
            wd           <= '0;
            sensor_fault <= 1'b0;
            en_o         <= 1'b0;
            aviso        <= 1'b0;
            alarma       <= 1'b0;
            vent         <= 1'b0;
            level        <= 3'd0;
        end else begin
            state        <= state_n;
            pcnt         <= pcnt_n;
            pdir         <= pdir_n;
            vcnt         <= vcnt_n;
            wd           <= wd_n;
            sensor_fault <= fault_n;
            en_o         <= state_n != IDLE;
            aviso        <= state_n == WARN;
            alarma       <= (state_n == ALARM) || (state_n == VENT);
            vent         <= state_n == VENT;
            level        <= state_n;
        end
    end

endmodule

// File: tb/tb_sensor_event_gen.sv
// Scoreboard bench for sensor_event_gen: directed plan plus random
// stimulus, checked against a rule-level reference model.
module tb_sensor_event_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       en_o, aviso, alarma, vent, sensor_fault;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    sensor_event_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample       (sample),
        .en_o         (en_o),
        .aviso        (aviso),
        .alarma       (alarma),
        .vent         (vent),
        .sensor_fault (sensor_fault),
        .level        (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       av;
        logic       al;
        logic       vt;
        logic       ft;
        logic [2:0] lv;
    } exp_t;

    exp_t q[$];

    // Reference model: level 0..4, consecutive-run length and direction,
    // samples spent in alarm, idle cycles since last sample.
    int m_st, m_run, m_rdir, m_vent, m_idle;
    bit m_fault;

    task automatic model_step(input bit rs, input bit en, input bit v, input int s);
        int dir;
        bit moved;
        if (rs || !en) begin
            m_st = 0; m_run = 0; m_rdir = 0; m_vent = 0; m_idle = 0; m_fault = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_fault) begin
            m_fault = 1;
        end else if (!v) begin
            m_idle++;
            if (m_idle >= 64) m_fault = 1;
        end else begin
            m_idle = 0;
            dir = 0;
            case (m_st)
                1: if (s >= 100) dir = 1;
                2: if (s >= 150) dir = 1; else if (s < 90) dir = -1;
                3, 4: if (s < 140) dir = -1;
                default: dir = 0;
            endcase
            if (dir == 0) m_run = 0;
            else if (dir == m_rdir && m_run > 0) m_run++;
            else m_run = 1;
            m_rdir = dir;
            moved = 0;
            if (m_st == 3) m_vent++;
            if (dir != 0 && m_run >= 3) begin
                m_st = (m_st == 4) ? 1 : m_st + dir;
                moved = 1;
            end else if (m_st == 3 && m_vent >= 5) begin
                m_st = 4;
                moved = 1;
            end
            if (moved) begin
                m_run = 0; m_rdir = 0; m_vent = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.en = (m_st != 0);
        e.av = (m_st == 2);
        e.al = (m_st == 3) || (m_st == 4);
        e.vt = (m_st == 4);
        e.ft = m_fault;
        e.lv = 3'(m_st);
        return e;
    endfunction

    task automatic step(input bit rs, input bit en, input bit v, input int s);
        @(negedge clk);
        reset        = rs;
        enable       = en;
        sample_valid = v;
        sample       = 8'(s);
        model_step(rs, en, v, s);
        q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: the outputs are presented every cycle; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e, g;
                e = q.pop_front();
                g = {en_o, aviso, alarma, vent, sensor_fault, level};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got en=%b av=%b al=%b vt=%b ft=%b lv=%0d want en=%b av=%b al=%b vt=%b ft=%b lv=%0d",
                             $time, g.en, g.av, g.al, g.vt, g.ft, g.lv,
                             e.en, e.av, e.al, e.vt, e.ft, e.lv);
                end
            end
        end
    end

    initial begin
        int base;
        base = 120;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_level", level, 0);
        chk("reset_outs", {en_o, aviso, alarma, vent, sensor_fault}, 0);

        // 1: arm and warn
        step(0, 1, 0, 0);
        chk("t1_normal", level, 1);
        chk("t1_en", en_o, 1);
        step(0, 1, 1, 120);
        step(0, 1, 1, 120);
        chk("t1_no_early_aviso", aviso, 0);
        step(0, 1, 1, 120);
        chk("t1_aviso", aviso, 1);
        chk("t1_warn", level, 2);

        // 2: interrupted run, then alarm
        step(0, 1, 1, 160);
        step(0, 1, 1, 95);
        step(0, 1, 1, 160);
        step(0, 1, 1, 160);
        chk("t2_still_warn", level, 2);
        step(0, 1, 1, 160);
        chk("t2_alarma", alarma, 1);
        chk("t2_aviso_drop", aviso, 0);

        // 3: vent delay, then fall to normal
        repeat (4) step(0, 1, 1, 160);
        chk("t3_no_early_vent", vent, 0);
        step(0, 1, 1, 160);
        chk("t3_vent", vent, 1);
        chk("t3_level4", level, 4);
        repeat (3) step(0, 1, 1, 139);
        chk("t3_back_normal", level, 1);
        chk("t3_events_drop", {aviso, alarma, vent}, 0);

        // 4: hysteresis in warn
        repeat (3) step(0, 1, 1, 120);
        repeat (3) step(0, 1, 1, 95);
        chk("t4_hyst_hold", level, 2);
        repeat (3) step(0, 1, 1, 89);
        chk("t4_fall", level, 1);
        chk("t4_aviso0", aviso, 0);

        // 5: watchdog in alarm
        repeat (3) step(0, 1, 1, 120);
        repeat (3) step(0, 1, 1, 160);
        repeat (4) step(0, 1, 1, 160);
        repeat (63) step(0, 1, 0, 0);
        chk("t5_no_early_fault", sensor_fault, 0);
        step(0, 1, 0, 0);
        chk("t5_fault", sensor_fault, 1);
        chk("t5_alarma_held", alarma, 1);
        repeat (3) step(0, 1, 1, 160);
        chk("t5_frozen", level, 3);
        step(0, 0, 0, 0);
        chk("t5_idle", level, 0);
        chk("t5_cleared", {en_o, aviso, alarma, vent, sensor_fault}, 0);

        // 6: reset while in vent
        step(0, 1, 0, 0);
        repeat (3) step(0, 1, 1, 120);
        repeat (3) step(0, 1, 1, 160);
        repeat (5) step(0, 1, 1, 160);
        chk("t6_in_vent", level, 4);
        step(1, 1, 1, 160);
        chk("t6_reset", {en_o, aviso, alarma, vent, sensor_fault, level}, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 200);
        step(0, 1, 1, 200);
        chk("t6_no_aviso", aviso, 0);
        chk("t6_normal", level, 1);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            int s;
            bit v, en, rs;
            if (i % 12 == 0) begin
                case ($urandom_range(0, 5))
                    0: base = 60;
                    1: base = 95;
                    2: base = 120;
                    3: base = 145;
                    4: base = 175;
                    default: base = 230;
                endcase
            end
            s = base + int'($urandom_range(0, 20)) - 10;
            if (s > 255) s = 255;
            v = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 299) != 0);
            rs = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0)
                repeat (70) step(0, 1, 0, 0);
            step(rs, en, v, s);
        end

        step(0, 1, 0, 0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
